imul_int_mul_iter_param: RTL and testbench

Parametrised iterative multiplier, successor to the single-cycle fixed-width multiplier. It accepts one NBITS x NBITS request over a val/rdy interface and computes the full 2*NBITS product with a radix-2 shift-add datapath, one iteration per cycle. It returns the low or high half, selected per request: mul, mulh, mulhu or mulhsu, with RISC-V M semantics. It sits behind the processor's muldiv unit request/response queues.

---
 rtl/imul_pkg.sv | 32 +++
 rtl/imul_int_mul_iter_dpath.sv | 114 +++++++++++
 rtl/imul_int_mul_iter_param.sv | 101 ++++++++++
 tb/tb_imul_int_mul_iter_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/imul_pkg.sv
// Shared types for the iterative integer multiplier: operation encodings,
// control FSM states and small operation-decode helpers.
package imul_pkg;

    typedef enum logic [1:0] {
        IMUL_OP_MUL    = 2'b00,
        IMUL_OP_MULH   = 2'b01,
        IMUL_OP_MULHU  = 2'b10,
        IMUL_OP_MULHSU = 2'b11
    } imul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } imul_state_e;

    // Operand a is signed for mulh and mulhsu; plain mul is handled unsigned
    // because the low half of the product does not depend on signedness.
    function automatic logic op_a_signed(input imul_op_e op);
        return (op == IMUL_OP_MULH) || (op == IMUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input imul_op_e op);
        return (op == IMUL_OP_MULH);
    endfunction

    function automatic logic op_high_half(input imul_op_e op);
        return (op != IMUL_OP_MUL);
    endfunction

endpackage

// File: rtl/imul_int_mul_iter_dpath.sv
// Datapath of the iterative multiplier: sign/magnitude capture, radix-2
// shift-add accumulation, final sign correction and result half select.
module imul_int_mul_iter_dpath
    import imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             calc_i,
    input  logic             add_i,
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic             b_lsb_o,
    output logic             counter_done_o,
    output logic [NBITS-1:0] result_o
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(NBITS - 1);
    localparam logic [CW-1:0]      ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [NBITS-1:0]   ONE_N    = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [2*NBITS-1:0] ONE_2N   = {{(2*NBITS-1){1'b0}}, 1'b1};

    imul_op_e             op_s;
    imul_op_e             op_q;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [NBITS-1:0]     abs_a_s;
    logic [NBITS-1:0]     abs_b_s;
    logic [2*NBITS-1:0]   sum_s;
    logic [2*NBITS-1:0]   final_s;
    logic [2*NBITS-1:0]   mcand_q;
    logic [NBITS-1:0]     mult_q;
    logic [2*NBITS-1:0]   product_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;

    // Operand magnitudes; abs of the most-negative value still fits unsigned.
    always_comb begin
        op_s    = imul_op_e'(op_i);
        a_neg_s = op_a_signed(op_s) & a_i[NBITS-1];
        b_neg_s = op_b_signed(op_s) & b_i[NBITS-1];
        if (a_neg_s) begin
            abs_a_s = ~a_i + ONE_N;
        end else begin
            abs_a_s = a_i;
        end
        if (b_neg_s) begin
            abs_b_s = ~b_i + ONE_N;
        end else begin
            abs_b_s = b_i;
        end
    end

    // Partial-product accumulation and sign correction of the final sum.
    always_comb begin
        if (add_i) begin
            sum_s = product_q + mcand_q;
        end else begin
            sum_s = product_q;
        end
        if (neg_q) begin
            final_s = ~sum_s + ONE_2N;
        end else begin
            final_s = sum_s;
        end
    end

    // Operand capture on accept, then one shift-add iteration per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q      <= IMUL_OP_MUL;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mult_q    <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else if (load_i) begin
            op_q      <= op_s;
            neg_q     <= a_neg_s ^ b_neg_s;
            mcand_q   <= {{NBITS{1'b0}}, abs_a_s};
            mult_q    <= abs_b_s;
            product_q <= '0;
            cnt_q     <= '0;
        end else if (calc_i) begin
            mcand_q   <= {mcand_q[2*NBITS-2:0], 1'b0};
            mult_q    <= {1'b0, mult_q[NBITS-1:1]};
            cnt_q     <= cnt_q + ONE_CNT;
            product_q <= counter_done_o ? final_s : sum_s;
        end else begin
            op_q      <= op_q;
            neg_q     <= neg_q;
            mcand_q   <= mcand_q;
            mult_q    <= mult_q;
            product_q <= product_q;
            cnt_q     <= cnt_q;
        end
    end

    // Status to control and the requested product half.
    always_comb begin
        b_lsb_o        = mult_q[0];
        counter_done_o = (cnt_q == CNT_LAST);
        if (op_high_half(op_q)) begin
            result_o = product_q[2*NBITS-1:NBITS];
        end else begin
            result_o = product_q[NBITS-1:0];
        end
    end

endmodule

// File: rtl/imul_int_mul_iter_param.sv
// Iterative NBITS x NBITS multiplier (mul/mulh/mulhu/mulhsu) behind a
// val/rdy request/response interface; control FSM lives here.
module imul_int_mul_iter_param
    import imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_msg_a,
    input  logic [NBITS-1:0] req_msg_b,
    input  logic [1:0]       req_msg_op,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg
);

    imul_state_e state_q;
    imul_state_e state_d;
    logic        req_rdy_s;
    logic        resp_val_s;
    logic        load_s;
    logic        calc_s;
    logic        add_s;
    logic        b_lsb_s;
    logic        counter_done_s;

    imul_int_mul_iter_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk            (clk),
        .reset          (reset),
        .load_i         (load_s),
        .calc_i         (calc_s),
        .add_i          (add_s),
        .a_i            (req_msg_a),
        .b_i            (req_msg_b),
        .op_i           (req_msg_op),
        .b_lsb_o        (b_lsb_s),
        .counter_done_o (counter_done_s),
        .result_o       (resp_msg)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control; iteration count is fixed, no early exit.
    always_comb begin
        state_d    = state_q;
        req_rdy_s  = 1'b0;
        resp_val_s = 1'b0;
        load_s     = 1'b0;
        calc_s     = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy_s = 1'b1;
                if (req_val) begin
                    load_s  = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                calc_s = 1'b1;
                if (counter_done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                resp_val_s = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        add_s = calc_s & b_lsb_s;
    end

    // Handshake outputs are masked while reset is held so nothing leaks out.
    always_comb begin
        req_rdy  = reset & req_rdy_s;
        resp_val = reset & resp_val_s;
    end

endmodule

// File: tb/tb_imul_int_mul_iter_param.sv
// Directed and random bench for imul_int_mul_iter_param at NBITS=32 and NBITS=8
// with a queue scoreboard of expected responses.
`timescale 1ns/1ps
module tb_imul_int_mul_iter_param;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_val32, req_rdy32, resp_val32, resp_rdy32;
    logic [31:0] a32, b32, resp_msg32;
    logic [1:0]  op32;
    logic        req_val8, req_rdy8, resp_val8, resp_rdy8;
    logic [7:0]  a8, b8, resp_msg8;
    logic [1:0]  op8;

    int errs = 0;
    int checks = 0;
    logic [31:0] q32[$];
    logic [7:0]  q8[$];

    imul_int_mul_iter_param #(.NBITS(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_val(req_val32), .req_rdy(req_rdy32),
        .req_msg_a(a32), .req_msg_b(b32), .req_msg_op(op32),
        .resp_val(resp_val32), .resp_rdy(resp_rdy32), .resp_msg(resp_msg32)
    );

    imul_int_mul_iter_param #(.NBITS(8)) dut8 (
        .clk(clk), .reset(reset),
        .req_val(req_val8), .req_rdy(req_rdy8),
        .req_msg_a(a8), .req_msg_b(b8), .req_msg_op(op8),
        .resp_val(resp_val8), .resp_rdy(resp_rdy8), .resp_msg(resp_msg8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: extend operands to double width per op, multiply, pick half.
    function automatic logic [31:0] ref32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (op == 2'b01 || op == 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
        be = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ae * be;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [7:0] ref8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ae, be, p;
        ae = (op == 2'b01 || op == 2'b11) ? {{8{a[7]}}, a} : {8'd0, a};
        be = (op == 2'b01) ? {{8{b[7]}}, b} : {8'd0, b};
        p  = ae * be;
        return (op == 2'b00) ? p[7:0] : p[15:8];
    endfunction

    task automatic txn32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stall, input string tag);
        int cyc;
        logic rdy_seen;
        logic [31:0] held;
        cyc = 0;
        while (req_rdy32 !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        chk({tag, "_req_rdy"}, {31'd0, req_rdy32}, 32'd1);
        resp_rdy32 = (stall == 0);
        req_val32 = 1'b1; op32 = op; a32 = a; b32 = b;
        q32.push_back(exp);
        @(negedge clk);
        req_val32 = 1'b0;
        cyc = 1;
        rdy_seen = 1'b0;
        while (resp_val32 !== 1'b1 && cyc < 100) begin
            if (req_rdy32 !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_resp_val"}, {31'd0, resp_val32}, 32'd1);
        chk({tag, "_latency"}, cyc, 32'd33);
        chk({tag, "_busy_rdy"}, {31'd0, rdy_seen}, 32'd0);
        held = resp_msg32;
        chk(tag, resp_msg32, q32.pop_front());
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                req_val32 = 1'b1; a32 = $urandom; b32 = $urandom; op32 = 2'(i);
                @(negedge clk);
                chk({tag, "_stall_val"}, {31'd0, resp_val32}, 32'd1);
                chk({tag, "_stall_msg"}, resp_msg32, held);
                chk({tag, "_stall_rdy"}, {31'd0, req_rdy32}, 32'd0);
            end
            req_val32 = 1'b0;
        end
        resp_rdy32 = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, {31'd0, req_rdy32}, 32'd1);
        chk({tag, "_idle_val"}, {31'd0, resp_val32}, 32'd0);
    endtask

    task automatic txn8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string tag);
        int cyc;
        cyc = 0;
        while (req_rdy8 !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        chk({tag, "_req_rdy"}, {31'd0, req_rdy8}, 32'd1);
        req_val8 = 1'b1; op8 = op; a8 = a; b8 = b;
        q8.push_back(exp);
        @(negedge clk);
        req_val8 = 1'b0;
        cyc = 1;
        while (resp_val8 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk({tag, "_resp_val"}, {31'd0, resp_val8}, 32'd1);
        chk({tag, "_latency"}, cyc, 32'd9);
        chk(tag, {24'd0, resp_msg8}, {24'd0, q8.pop_front()});
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [7:0]  sa, sb;
        reset = 1'b0;
        req_val32 = 1'b0; a32 = '0; b32 = '0; op32 = 2'b00; resp_rdy32 = 1'b1;
        req_val8 = 1'b0;  a8 = '0;  b8 = '0;  op8 = 2'b00;  resp_rdy8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", {31'd0, req_rdy32}, 32'd0);
        chk("rst_resp_val", {31'd0, resp_val32}, 32'd0);
        chk("rst_req_rdy8", {31'd0, req_rdy8}, 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_rdy", {31'd0, req_rdy32}, 32'd1);
        chk("post_rst_msg", resp_msg32, 32'd0);
        chk("post_rst_val", {31'd0, resp_val32}, 32'd0);
        @(negedge clk);

        txn32(2'b00, 32'd3, 32'd4, 32'h0000000c, 0, "mul_3x4");
        txn32(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min");
        txn32(2'b01, 32'hffffffff, 32'hffffffff, 32'h00000000, 0, "mulh_m1");
        txn32(2'b00, 32'hffffffff, 32'hffffffff, 32'h00000001, 0, "mul_m1");
        txn32(2'b10, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 0, "mulhu_max");
        txn32(2'b11, 32'hffffffff, 32'hffffffff, 32'hffffffff, 0, "mulhsu_m1");
        txn32(2'b11, 32'h00000002, 32'h80000000, 32'h00000001, 0, "mulhsu_2");
        txn32(2'b01, 32'h12345678, 32'hfedcba98, ref32(2'b01, 32'h12345678, 32'hfedcba98), 5, "bp_first");
        txn32(2'b10, 32'hdeadbeef, 32'h0badf00d, ref32(2'b10, 32'hdeadbeef, 32'h0badf00d), 0, "bp_second");

        // Abort an operation at CALC iteration 10 with a one-cycle reset.
        req_val32 = 1'b1; op32 = 2'b00; a32 = 32'd123; b32 = 32'd456;
        @(negedge clk);
        req_val32 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_rdy_low", {31'd0, req_rdy32}, 32'd0);
        chk("midrst_val_low", {31'd0, resp_val32}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_val", {31'd0, resp_val32}, 32'd0);
        chk("midrst_msg", resp_msg32, 32'd0);
        chk("midrst_rdy", {31'd0, req_rdy32}, 32'd1);
        @(negedge clk);
        txn32(2'b00, 32'd7, 32'd6, 32'h0000002a, 0, "mul_7x6");

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
            txn32(rop, ra, rb, ref32(rop, ra, rb), 0, "rand32");
        end

        txn8(2'b01, 8'h80, 8'h7f, 8'hc0, "n8_mulh");
        txn8(2'b00, 8'h80, 8'h7f, 8'h80, "n8_mul");
        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom_range(0, 3)); sa = 8'($urandom); sb = 8'($urandom);
            txn8(rop, sa, sb, ref8(rop, sa, sb), "rand8");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
